// File: rtl/hazard_stall_if.sv
// Hazard/stall handshake bundle between the ID/EX pipeline stages and the
// load-use stall controller. The optional stall_cycles signal exists only
// when STALL_PERF_CNT_EN is defined.
interface hazard_stall_if #(
   parameter int REG_ADDR_W = 5,
   parameter int PERF_W     = 32
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic                  ex_valid;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  mem_busy;
   logic                  flush;
   logic                  pc_write;
   logic                  if_id_write;
   logic                  ctrl_bubble;
   logic                  stall_active;
`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0]     stall_cycles;
`endif

   // Pipeline side: presents stage contents, consumes the stall controls.
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output ex_valid, ex_mem_read, ex_rd, mem_busy, flush,
`ifdef STALL_PERF_CNT_EN
      input  stall_cycles,
`endif
      input  pc_write, if_id_write, ctrl_bubble, stall_active
   );

   // Controller side.
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  ex_valid, ex_mem_read, ex_rd, mem_busy, flush,
`ifdef STALL_PERF_CNT_EN
      output stall_cycles,
`endif
      output pc_write, if_id_write, ctrl_bubble, stall_active
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use hazard detection and stall sequencer.
// Detects an ID-stage instruction reading the destination of a load in EX
// (x0 never hazards), inserts LOAD_LAT bubbles via a small counter FSM,
// freezes the whole pipeline on mem_busy and aborts stalls on flush.
// Optional macro STALL_PERF_CNT_EN adds the stall_cycles bubble counter.
module hazard_stall_controller #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 3,
   parameter int PERF_W     = 32
) (
   input logic           clk,
   input logic           rst,
   hazard_stall_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   // Counter value on entering STALL: the first bubble is issued from IDLE.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             hit;
   logic             pc_write, if_id_write, ctrl_bubble, stall_active;

   // Load-use match: a load in EX writes a register the ID instruction reads.
   always_comb begin
      hit = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != '0) &
            ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
             (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
   end

   // Prioritised Mealy outputs and next-state: rst, mem_busy, flush, FSM.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      ctrl_bubble  = 1'b0;
      stall_active = (state == STALL);
      if (rst) begin
         state_nxt    = IDLE;
         cnt_nxt      = '0;
         stall_active = 1'b0;
      end else if (bus.mem_busy) begin
         // Whole pipeline frozen; flush waits until the memory is ready.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (bus.flush) begin
         // ID is discarded, so a bubble goes down and any stall is dropped.
         ctrl_bubble = 1'b1;
         state_nxt   = IDLE;
         cnt_nxt     = '0;
      end else if (state == IDLE) begin
         if (hit) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ctrl_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
               state_nxt = STALL;
               cnt_nxt   = CNT_INIT;
            end
         end
      end else begin
         // EX holds our own bubble here, so hit is not re-evaluated.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ctrl_bubble = 1'b1;
         cnt_nxt     = cnt - 1'b1;
         if (cnt == CNT_LAST) state_nxt = IDLE;
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.if_id_write  = if_id_write;
   assign bus.ctrl_bubble  = ctrl_bubble;
   assign bus.stall_active = stall_active;

   // State and bubble counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments to avoid races.
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cycles;

   // Count every bubble actually issued (frozen cycles excluded); wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (ctrl_bubble && !bus.mem_busy) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign bus.stall_cycles = stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Three instances with
// LOAD_LAT = 1, 2, 3 share one set of stimulus; each test checks the
// instance(s) it targets. The stall_cycles check is built only when
// STALL_PERF_CNT_EN is defined.
module tb_hazard_stall_controller;

   localparam int REG_ADDR_W = 5;
   localparam int PERF_W     = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  id_valid, id_rs1_used, id_rs2_used;
   logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
   logic                  ex_valid, ex_mem_read, mem_busy, flush;

   logic [2:0] pcw, ifw, bub, sa;
`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0] perf [3];
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instance k has LOAD_LAT = k + 1.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_stall_if #(.REG_ADDR_W(REG_ADDR_W), .PERF_W(PERF_W)) bus ();

      hazard_stall_controller #(
         .REG_ADDR_W(REG_ADDR_W),
         .LOAD_LAT  (g + 1),
         .CNT_W     (3),
         .PERF_W    (PERF_W)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus.slave)
      );

      assign bus.id_valid    = id_valid;
      assign bus.id_rs1      = id_rs1;
      assign bus.id_rs2      = id_rs2;
      assign bus.id_rs1_used = id_rs1_used;
      assign bus.id_rs2_used = id_rs2_used;
      assign bus.ex_valid    = ex_valid;
      assign bus.ex_mem_read = ex_mem_read;
      assign bus.ex_rd       = ex_rd;
      assign bus.mem_busy    = mem_busy;
      assign bus.flush       = flush;
      assign pcw[g]          = bus.pc_write;
      assign ifw[g]          = bus.if_id_write;
      assign bub[g]          = bus.ctrl_bubble;
      assign sa[g]           = bus.stall_active;
`ifdef STALL_PERF_CNT_EN
      assign perf[g]         = bus.stall_cycles;
`endif
   end

   // {pc_write, if_id_write, ctrl_bubble} of instance k.
   function automatic logic [2:0] outs(input int k);
      return {pcw[k], ifw[k], bub[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
      mem_busy = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Load in EX writing rd, ID instruction reading rs1/rs2 as flagged.
   task automatic set_hazard(input logic [REG_ADDR_W-1:0] rd,
                             input logic [REG_ADDR_W-1:0] rs1, input logic u1,
                             input logic [REG_ADDR_W-1:0] rs2, input logic u2);
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
      id_valid = 1'b1; id_rs1 = rs1; id_rs1_used = u1;
      id_rs2 = rs2; id_rs2_used = u2;
   endtask

   task automatic test_reset();
      clear_inputs();
      set_hazard(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      rst = 1'b1;
      settle();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({outs(k), sa[k]} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outs[%0d] got=%b exp=1100", k, {outs(k), sa[k]});
         end
      end
      tick();
      do_reset();
   endtask

   task automatic test_ll1_basic();
      do_reset();
      set_hazard(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      settle();
      checks++;
      if ({outs(0), sa[0]} !== 4'b0010) begin
         errors++; $display("FAIL ll1_bubble got=%b exp=0010", {outs(0), sa[0]});
      end
      tick();
      ex_valid = 1'b0;
      settle();
      checks++;
      if (outs(0) !== 3'b110) begin
         errors++; $display("FAIL ll1_release got=%b exp=110", outs(0));
      end
   endtask

   task automatic test_no_hazard();
      do_reset();
      set_hazard(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      settle();
      checks++;
      if (outs(0) !== 3'b110 || outs(2) !== 3'b110) begin
         errors++; $display("FAIL x0_exclusion got=%b/%b exp=110/110", outs(0), outs(2));
      end
      set_hazard(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
      #1;
      checks++;
      if (outs(0) !== 3'b110) begin
         errors++; $display("FAIL rs2_unused got=%b exp=110", outs(0));
      end
      ex_mem_read = 1'b0; id_rs2_used = 1'b1;
      #1;
      checks++;
      if (outs(0) !== 3'b110) begin
         errors++; $display("FAIL not_a_load got=%b exp=110", outs(0));
      end
      ex_mem_read = 1'b1;
      #1;
      checks++;
      if (outs(0) !== 3'b001) begin
         errors++; $display("FAIL rs2_used_hit got=%b exp=001", outs(0));
      end
   endtask

   task automatic test_ll3_stall();
      logic [3:0] exp [4] = '{4'b0010, 4'b0011, 4'b0011, 4'b1100};
      do_reset();
      set_hazard(5'd9, 5'd1, 1'b0, 5'd9, 1'b1);
      for (int c = 0; c < 4; c++) begin
         settle();
         checks++;
         if ({outs(2), sa[2]} !== exp[c]) begin
            errors++;
            $display("FAIL ll3_cycle%0d got=%b exp=%b", c + 1, {outs(2), sa[2]}, exp[c]);
         end
         tick();
         ex_valid = 1'b0;
      end
   endtask

   task automatic test_mem_busy();
      logic [3:0] exp [6] = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1100};
      int held = 0;
      do_reset();
      set_hazard(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         mem_busy = (c == 1 || c == 2);
         settle();
         checks++;
         if ({outs(2), sa[2]} !== exp[c]) begin
            errors++;
            $display("FAIL busy_cycle%0d got=%b exp=%b", c + 1, {outs(2), sa[2]}, exp[c]);
         end
         if (pcw[2] === 1'b0) held++;
         tick();
         ex_valid = 1'b0;
      end
      mem_busy = 1'b0;
      checks++;
      if (held !== 5) begin
         errors++; $display("FAIL busy_total got=%0d exp=5", held);
      end
   endtask

   task automatic test_flush_and_rst();
      do_reset();
      set_hazard(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      tick();
      ex_valid = 1'b0;
      flush = 1'b1;
      settle();
      checks++;
      if (outs(2) !== 3'b111) begin
         errors++; $display("FAIL flush_cycle got=%b exp=111", outs(2));
      end
      tick();
      flush = 1'b0; id_valid = 1'b0;
      settle();
      checks++;
      if ({outs(2), sa[2]} !== 4'b1100) begin
         errors++; $display("FAIL after_flush got=%b exp=1100", {outs(2), sa[2]});
      end
      set_hazard(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      tick();
      ex_valid = 1'b0;
      rst = 1'b1;
      settle();
      checks++;
      if ({outs(2), sa[2]} !== 4'b1100) begin
         errors++; $display("FAIL rst_in_stall got=%b exp=1100", {outs(2), sa[2]});
      end
      tick();
      rst = 1'b0;
      settle();
      checks++;
      if ({outs(2), sa[2]} !== 4'b1100) begin
         errors++; $display("FAIL after_rst got=%b exp=1100", {outs(2), sa[2]});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // LOAD_LAT=3 with a fresh hazard present the cycle the stall ends.
      set_hazard(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      tick(); tick(); tick();
      settle();
      checks++;
      if ({outs(2), sa[2]} !== 4'b0010) begin
         errors++; $display("FAIL b2b_ll3 got=%b exp=0010", {outs(2), sa[2]});
      end
      // LOAD_LAT=1: bubble, one clean cycle, then a new dependent load.
      do_reset();
      set_hazard(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      tick();
      ex_valid = 1'b0;
      tick();
      set_hazard(5'd6, 5'd1, 1'b0, 5'd6, 1'b1);
      settle();
      checks++;
      if (outs(0) !== 3'b001) begin
         errors++; $display("FAIL b2b_ll1 got=%b exp=001", outs(0));
      end
   endtask

`ifdef STALL_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      for (int h = 0; h < 2; h++) begin
         set_hazard(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
         tick(); tick();
         clear_inputs();
         tick();
      end
      checks++;
      if (perf[1] !== 32'd4) begin
         errors++; $display("FAIL perf_count got=%0d exp=4", perf[1]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (perf[1] !== 32'd0) begin
         errors++; $display("FAIL perf_reset got=%0d exp=0", perf[1]);
      end
   endtask
`endif

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      test_reset();
      test_ll1_basic();
      test_no_hazard();
      test_ll3_stall();
      test_mem_busy();
      test_flush_and_rst();
      test_back_to_back();
`ifdef STALL_PERF_CNT_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Parametrised load-use hazard detection and stall sequencer for the in-order pipeline, sitting between the ID stage and the IF/ID, PC and ID/EX control-mux logic. Generalises single-bubble load-use detection: per-operand use flags replace opcode decoding, x0 never hazards, LOAD_LAT bubbles are inserted by a counter FSM, and data-memory busy freezes and flush handling are built in.

Parameters:
REG_ADDR_W, 5, register index width
LOAD_LAT, 1, bubbles required between a load in EX and a dependent instruction in ID (legal 1..7)
CNT_W, 3, stall counter width (must hold LOAD_LAT)
PERF_W, 32, stall performance counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_ADDR_W  ID source 1 index
id_rs2  in  REG_ADDR_W  ID source 2 index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
ex_valid  in  1  EX stage holds a real instruction
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_ADDR_W  EX destination index
mem_busy  in  1  data memory not ready; whole pipeline must freeze
flush  in  1  branch/jump redirect; ID contents are discarded
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register write enable
ctrl_bubble  out  1  select zero control word into ID/EX
stall_active  out  1  FSM is in STALL
stall_cycles  out  PERF_W  total bubble count (only with STALL_PERF_CNT_EN)

Behaviour:
- hit = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)); purely combinational.
- States: IDLE, STALL. Registered counter cnt (CNT_W bits).
- Outputs are Mealy and combinational from state, cnt and inputs. Evaluate in this priority order; the first rule that applies sets all outputs:
- 1. rst=1: pc_write=1, if_id_write=1, ctrl_bubble=0, stall_active=0. Next state IDLE, cnt=0.
- 2. mem_busy=1: pc_write=0, if_id_write=0, ctrl_bubble=0. State and cnt hold. flush is ignored; upstream must hold flush until mem_busy drops.
- 3. flush=1: pc_write=1, if_id_write=1, ctrl_bubble=1. Next state IDLE, cnt=0. This aborts any stall in progress.
- 4. IDLE with hit: pc_write=0, if_id_write=0, ctrl_bubble=1. If LOAD_LAT=1, stay in IDLE. Otherwise go to STALL with cnt=LOAD_LAT-1.
- 5. IDLE without hit: pc_write=1, if_id_write=1, ctrl_bubble=0.
- 6. STALL: pc_write=0, if_id_write=0, ctrl_bubble=1, stall_active=1. cnt decrements each cycle. When cnt==1, next state is IDLE. hit is not re-evaluated in STALL, because EX holds a bubble.
- Latency: detection to bubble is 0 cycles (same cycle). A dependent instruction leaves ID after exactly LOAD_LAT bubbles, excluding mem_busy cycles.
- After returning to IDLE, hit is evaluated afresh (for example, a back-to-back load in EX).
- Registered state: state, cnt, and stall_cycles when the feature is enabled.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: stall_cycles increments by 1 on every cycle with ctrl_bubble=1 and mem_busy=0. It wraps at 2^PERF_W and is cleared by rst.
- Undefined: the stall_cycles port and its counter are absent.

Test Plan:
- LOAD_LAT=1, ex load rd=5, id rs1=5, rs1_used=1 -> one cycle of pc_write=0, if_id_write=0, ctrl_bubble=1; next cycle ex_valid=0, outputs 1/1/0.
- ex load rd=0, id rs1=0 used -> no stall (x0 exclusion). Load rd=7, id rs2=7 with rs2_used=0 -> no stall.
- LOAD_LAT=3, load rd=9, id rs2=9 -> exactly 3 consecutive bubble cycles, stall_active high for cycles 2-3, then IDLE.
- LOAD_LAT=3: mem_busy=1 for 2 cycles during the 2nd bubble -> outputs 0/0/0 and cnt frozen; 5 cycles total before release.
- LOAD_LAT=3: flush=1 during STALL with cnt=2 -> outputs 1/1/1 that cycle, IDLE the next cycle. rst=1 during STALL -> IDLE and outputs 1/1/0.
- STALL_PERF_CNT_EN, LOAD_LAT=2, two separate load-use hazards -> stall_cycles=4; after rst, stall_cycles=0.
